// File: rtl/ds_adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ds_adc_pkg                                                           |
// | Widths and types shared by the delta-sigma modulator and decimator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ds_adc_pkg;

  localparam int DS_DATA_W = 8;
  localparam int DS_OSR_W  = 8;

  typedef logic [DS_DATA_W-1:0] ds_code_t;
  typedef logic [DS_OSR_W-1:0]  ds_osr_t;

endpackage
`default_nettype wire

// File: rtl/ds_mod_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ds_mod_core                                                          |
// | First-order accumulator; the adder carry is the output bit.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ds_mod_core
  import ds_adc_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_code,
  output logic              o_bs
);

  logic [DATA_W-1:0] r_acc;
  logic              r_bs;
  logic [DATA_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_code};

  // The residue in r_acc is never cleared between codes, so the
  // quantisation error carries over frame boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_bs  <= 1'b0;
    end else if (i_en) begin
      r_bs  <= w_sum[DATA_W];
      r_acc <= w_sum[DATA_W-1:0];
    end
  end

  assign o_bs = r_bs;

endmodule
`default_nettype wire

// File: rtl/ds_bitstream_mod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ds_bitstream_mod                                                     |
// | Parallel code to 1-bit pulse-density stream, one code per frame.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ds_bitstream_mod
  import ds_adc_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W,
  parameter int OSR_W  = DS_OSR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [OSR_W-1:0]  osr_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              bs_o,
  output logic              frame_o,
  output logic              underrun_o,
  output logic              underrun_sticky_o,
  input  logic              clr_i
);

  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_cur_code;
  logic [OSR_W-1:0]  r_osr_cnt;
  logic [OSR_W-1:0]  r_osr_len;
  logic              r_frame;
  logic              r_underrun;
  logic              r_sticky;

  logic w_xfer;
  logic w_frame_end;
  logic w_underrun;

  assign s_ready_o   = ~r_hold_valid;
  assign w_xfer      = s_valid_i & ~r_hold_valid;
  assign w_frame_end = en_i & (r_osr_cnt == r_osr_len);
  assign w_underrun  = w_frame_end & ~r_hold_valid;

  // A transfer needs an empty holding register and a load needs a full
  // one, so the two never collide on r_hold_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_cur_code   <= '0;
      r_osr_cnt    <= '0;
      r_osr_len    <= '0;
    end else begin
      if (w_xfer) begin
        r_hold_data  <= s_data_i;
        r_hold_valid <= 1'b1;
      end
      if (w_frame_end) begin
        r_osr_cnt <= '0;
        r_osr_len <= osr_i;
        if (r_hold_valid) begin
          r_cur_code   <= r_hold_data;
          r_hold_valid <= 1'b0;
        end
      end else if (en_i) begin
        r_osr_cnt <= r_osr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_frame    <= w_frame_end & r_hold_valid;
      r_underrun <= w_underrun;
      r_sticky   <= w_underrun | (r_sticky & ~clr_i);
    end
  end

  ds_mod_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en_i),
    .i_code (r_cur_code),
    .o_bs   (bs_o)
  );

  assign frame_o           = r_frame;
  assign underrun_o        = r_underrun;
  assign underrun_sticky_o = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ds_bitstream_mod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ds_bitstream_mod                                                  |
// | Scoreboard bench: per-frame tick/ones/prefix expectations.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ds_bitstream_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i;
  logic [7:0] osr_i;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic       bs_o;
  logic       frame_o;
  logic       underrun_o;
  logic       underrun_sticky_o;
  logic       clr_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         under;
    int         ticks;
    int         ones;
    logic [3:0] pre;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ds_bitstream_mod dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .en_i              (en_i),
    .osr_i             (osr_i),
    .s_data_i          (s_data_i),
    .s_valid_i         (s_valid_i),
    .s_ready_o         (s_ready_o),
    .bs_o              (bs_o),
    .frame_o           (frame_o),
    .underrun_o        (underrun_o),
    .underrun_sticky_o (underrun_sticky_o),
    .clr_i             (clr_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input bit under, input int ticks, input int ones,
                              input logic [3:0] pre, input logic [3:0] mask);
    exp_t e;
    e.under = under; e.ticks = ticks; e.ones = ones; e.pre = pre; e.mask = mask;
    sb.push_back(e);
  endtask

  // Monitor: accumulate bits of enabled ticks, close a frame on frame_o/underrun_o.
  logic tick_q = 1'b0;
  logic rst_q  = 1'b0;
  always @(posedge clk) begin
    tick_q <= en_i & rst_n;
    rst_q  <= rst_n;
  end

  initial begin
    int         m_ticks;
    int         m_ones;
    logic [3:0] m_pre;
    exp_t       e;
    m_ticks = 0; m_ones = 0; m_pre = '0;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        m_ticks = 0; m_ones = 0; m_pre = '0;
      end else begin
        if (tick_q) begin
          if (m_ticks < 4) m_pre[m_ticks] = bs_o;
          m_ones += int'(bs_o);
          m_ticks++;
        end
        if (frame_o || underrun_o) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_event", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("evt_kind_underrun", underrun_o, e.under);
            chk("evt_kind_frame", frame_o, !e.under);
            chk("frame_ticks", m_ticks, e.ticks);
            chk("frame_ones", m_ones, e.ones);
            chk("frame_prefix", m_pre & e.mask, e.pre & e.mask);
          end
          m_ticks = 0; m_ones = 0; m_pre = '0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] code);
    int n;
    n = 0;
    s_data_i  = code;
    s_valid_i = 1'b1;
    while (!s_ready_o && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) chk("push_timeout", 1, 0);
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_evt(input bit under, input int maxc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(under ? underrun_o : frame_o) && n < maxc);
    if (!(under ? underrun_o : frame_o)) chk(name, 0, 1);
  endtask

  initial begin
    logic prev_bs;
    int   cyc;
    bit   got;
    rst_n = 1'b0; en_i = 1'b0; osr_i = 8'd255; s_data_i = '0;
    s_valid_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bs", bs_o, 0);
    chk("rst_frame", frame_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_sticky", underrun_sticky_o, 0);
    chk("rst_ready", s_ready_o, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // First tick after reset is a 1-tick frame of code 0 that loads code 0.
    expect_frame(1'b0, 1, 0, 4'b0000, 4'b0001);
    push(8'd0);
    chk("ready_low_after_push", s_ready_o, 0);
    en_i = 1'b1;
    expect_frame(1'b0, 256, 0, 4'b0000, 4'b1111);
    push(8'd128);
    expect_frame(1'b0, 256, 128, 4'b1010, 4'b1111);
    push(8'd255);
    expect_frame(1'b0, 256, 255, 4'b1110, 4'b1111);
    push(8'd37);
    expect_frame(1'b0, 256, 37, 4'b0000, 4'b1111);
    wait_evt(1'b0, 300, "timeout_load37");

    // Code 37 with en_i toggling; 10 and 200 offered back-to-back.
    s_valid_i = 1'b1; s_data_i = 8'd10; en_i = 1'b0;
    prev_bs = bs_o; cyc = 0; got = 1'b0;
    while (!got && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (!en_i) chk("bs_frozen", bs_o, prev_bs);
      prev_bs = bs_o;
      if (cyc == 1) begin
        chk("ready_drop_after_10", s_ready_o, 0);
        s_data_i = 8'd200;
      end
      if (frame_o) got = 1'b1;
      else en_i = ~en_i;
    end
    if (!got) chk("timeout_load10", 0, 1);
    chk("ready_rise_at_frame", s_ready_o, 1);
    en_i = 1'b1;
    expect_frame(1'b0, 256, 10, 4'b0000, 4'b1111);
    expect_frame(1'b1, 256, 200, 4'b1110, 4'b1111);
    @(negedge clk);
    chk("ready_low_200_taken", s_ready_o, 0);
    s_valid_i = 1'b0;
    wait_evt(1'b0, 300, "timeout_load200");
    osr_i = 8'd3;

    // Underrun, code repeats for a 4-tick frame starting with acc=0.
    wait_evt(1'b1, 300, "timeout_underrun1");
    chk("sticky_set", underrun_sticky_o, 1);
    expect_frame(1'b1, 4, 3, 4'b1110, 4'b1111);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_clears", underrun_sticky_o, 0);
    osr_i = 8'd0;
    wait_evt(1'b1, 10, "timeout_underrun2");
    en_i = 1'b0;
    chk("sticky_set_again", underrun_sticky_o, 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("clr_idle", underrun_sticky_o, 0);
    // acc=32, code 200: 232 -> bit 0.
    expect_frame(1'b1, 1, 0, 4'b0000, 4'b0001);
    en_i = 1'b1; clr_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0; clr_i = 1'b0;
    chk("coincident_underrun", underrun_o, 1);
    chk("set_wins_over_clr", underrun_sticky_o, 1);

    // Load 99 (acc=232, code 200: 432 -> bit 1), then reset mid-frame.
    osr_i = 8'd255;
    expect_frame(1'b0, 1, 1, 4'b0001, 4'b0001);
    push(8'd99);
    en_i = 1'b1;
    wait_evt(1'b0, 5, "timeout_load99");
    repeat (50) @(negedge clk);
    push(8'd77);
    chk("pending_77", s_ready_o, 0);
    expect_frame(1'b1, 1, 0, 4'b0000, 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bs", bs_o, 0);
    chk("midrst_frame", frame_o, 0);
    chk("midrst_underrun", underrun_o, 0);
    chk("midrst_sticky", underrun_sticky_o, 0);
    chk("midrst_ready", s_ready_o, 1);
    rst_n = 1'b1;
    wait_evt(1'b1, 5, "timeout_post_reset_underrun");
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
